pps_edge_monitor: RTL and testbench

PPS_EDGE_MONITOR -- requirements
Module: pps_edge_monitor

---
 rtl/pps_edge_monitor.sv | 133 +++++++++++++
 tb/tb_pps_edge_monitor.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pps_edge_monitor.sv
// Pulse-per-second monitor: glitch-filters a synchronized PPS level, reports
// accepted rising edges, the period between them, and loss of signal.
module pps_edge_monitor #(
    parameter int unsigned FILTER_CYCLES  = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd125000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_signal_sync,
    input  logic        i_enable,
    output logic        o_edge_pulse,
    output logic        o_period_valid,
    output logic [31:0] o_period_cnt,
    output logic [15:0] o_edge_cnt,
    output logic        o_signal_lost
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2,
    LOST       = 2'd3
  } state_t;

  // Run value on the sample that completes a qualifying run of differing samples.
  localparam logic [7:0] FILT_LAST = 8'(FILTER_CYCLES - 1);

  state_t      state_r;
  logic        filt_r;
  logic        filt_d_r;
  logic [7:0]  run_r;
  logic [31:0] interval_r;
  logic [15:0] edge_cnt_r;
  logic        edge_pulse_r;
  logic        period_valid_r;
  logic [31:0] period_cnt_r;
  logic        signal_lost_r;
  logic        edge_s;

  assign edge_s         = filt_r & ~filt_d_r;
  assign o_edge_pulse   = edge_pulse_r;
  assign o_period_valid = period_valid_r;
  assign o_period_cnt   = period_cnt_r;
  assign o_edge_cnt     = edge_cnt_r;
  assign o_signal_lost  = signal_lost_r;

  // Glitch filter: a new level is accepted only after a full run of differing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt_r   <= 1'b0;
      filt_d_r <= 1'b0;
      run_r    <= 8'd0;
    end else begin
      filt_d_r <= filt_r;
      if (i_signal_sync != filt_r) begin
        if (run_r == FILT_LAST) begin
          filt_r <= i_signal_sync;
          run_r  <= 8'd0;
        end else begin
          run_r <= run_r + 8'd1;
        end
      end else begin
        run_r <= 8'd0;
      end
    end
  end

  // Monitor FSM with registered outputs; an edge always wins over the timeout check.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r        <= IDLE;
      interval_r     <= 32'd0;
      edge_cnt_r     <= 16'd0;
      edge_pulse_r   <= 1'b0;
      period_valid_r <= 1'b0;
      period_cnt_r   <= 32'd0;
      signal_lost_r  <= 1'b0;
    end else begin
      edge_pulse_r   <= 1'b0;
      period_valid_r <= 1'b0;
      if (!i_enable) begin
        state_r       <= IDLE;
        interval_r    <= 32'd0;
        edge_cnt_r    <= 16'd0;
        period_cnt_r  <= 32'd0;
        signal_lost_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r    <= WAIT_FIRST;
            interval_r <= 32'd0;
          end
          WAIT_FIRST, MEASURE: begin
            if (edge_s) begin
              edge_pulse_r <= 1'b1;
              edge_cnt_r   <= edge_cnt_r + 16'd1;
              interval_r   <= 32'd1;
              state_r      <= MEASURE;
              if (state_r == MEASURE) begin
                period_valid_r <= 1'b1;
                period_cnt_r   <= interval_r;
              end else begin
                period_valid_r <= 1'b0;
              end
            end else if (interval_r >= TIMEOUT_CYCLES) begin
              state_r       <= LOST;
              signal_lost_r <= 1'b1;
            end else begin
              interval_r <= interval_r + 32'd1;
            end
          end
          LOST: begin
            if (edge_s) begin
              edge_pulse_r  <= 1'b1;
              edge_cnt_r    <= edge_cnt_r + 16'd1;
              interval_r    <= 32'd1;
              signal_lost_r <= 1'b0;
              state_r       <= MEASURE;
            end else begin
              interval_r <= interval_r;
            end
          end
          default: begin
            state_r       <= IDLE;
            interval_r    <= 32'd0;
            signal_lost_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pps_edge_monitor.sv
// Directed bench for pps_edge_monitor with FILTER_CYCLES=4, TIMEOUT_CYCLES=100.
module tb_pps_edge_monitor;

  logic        clk;
  logic        rst_n;
  logic        sig;
  logic        enable;
  logic        o_edge_pulse;
  logic        o_period_valid;
  logic [31:0] o_period_cnt;
  logic [15:0] o_edge_cnt;
  logic        o_signal_lost;

  int checks = 0;
  int errors = 0;
  int pulse_total = 0;
  int valid_total = 0;
  logic [31:0] last_valid_period = 32'd0;

  pps_edge_monitor #(
      .FILTER_CYCLES (4),
      .TIMEOUT_CYCLES(32'd100)
  ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_signal_sync (sig),
      .i_enable      (enable),
      .o_edge_pulse  (o_edge_pulse),
      .o_period_valid(o_period_valid),
      .o_period_cnt  (o_period_cnt),
      .o_edge_cnt    (o_edge_cnt),
      .o_signal_lost (o_signal_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_edge_pulse) pulse_total = pulse_total + 1;
    if (o_period_valid) begin
      valid_total = valid_total + 1;
      last_valid_period = o_period_cnt;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_in(input int hi, input int lo);
    sig = 1'b1;
    tick(hi);
    sig = 1'b0;
    tick(lo);
  endtask

  task automatic test_reset();
    int p0;
    rst_n = 1'b0; enable = 1'b0; sig = 1'b1;
    tick(3);
    checks++;
    if ({o_edge_pulse, o_period_valid, o_period_cnt, o_edge_cnt, o_signal_lost} !== 51'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {o_edge_pulse, o_period_valid, o_period_cnt, o_edge_cnt, o_signal_lost});
    end
    sig = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    p0 = pulse_total;
    pulse_in(10, 6);
    checks++;
    if ((pulse_total - p0) !== 0 || o_edge_cnt !== 16'd0) begin
      errors++;
      $display("FAIL idle_no_pulse: got pulses=%0d cnt=%0d expected 0 0", pulse_total - p0, o_edge_cnt);
    end
  endtask

  task automatic test_first_edge();
    int p0, v0;
    enable = 1'b1;
    tick(2);
    p0 = pulse_total; v0 = valid_total;
    pulse_in(10, 6);
    checks++;
    if ((pulse_total - p0) !== 1) begin
      errors++; $display("FAIL first_pulse: got %0d expected 1", pulse_total - p0);
    end
    checks++;
    if ((valid_total - v0) !== 0) begin
      errors++; $display("FAIL first_no_valid: got %0d expected 0", valid_total - v0);
    end
    checks++;
    if (o_edge_cnt !== 16'd1) begin
      errors++; $display("FAIL first_edge_cnt: got %0d expected 1", o_edge_cnt);
    end
  endtask

  task automatic test_period();
    int v0;
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(2);
    v0 = valid_total;
    for (int i = 0; i < 3; i++) begin
      pulse_in(10, 40);
      if (i > 0) begin
        checks++;
        if (last_valid_period !== 32'd50 || o_period_cnt !== 32'd50) begin
          errors++;
          $display("FAIL period_50_%0d: got %0d/%0d expected 50", i, last_valid_period, o_period_cnt);
        end
      end
    end
    checks++;
    if ((valid_total - v0) !== 2) begin
      errors++; $display("FAIL period_valid_count: got %0d expected 2", valid_total - v0);
    end
    checks++;
    if (o_edge_cnt !== 16'd3) begin
      errors++; $display("FAIL period_edge_cnt: got %0d expected 3", o_edge_cnt);
    end
  endtask

  task automatic test_glitch();
    int p0;
    p0 = pulse_total;
    pulse_in(3, 10);
    checks++;
    if ((pulse_total - p0) !== 0 || o_edge_cnt !== 16'd3 || o_period_cnt !== 32'd50) begin
      errors++;
      $display("FAIL glitch_3: got pulses=%0d cnt=%0d period=%0d expected 0 3 50",
               pulse_total - p0, o_edge_cnt, o_period_cnt);
    end
    p0 = pulse_total;
    pulse_in(4, 10);
    checks++;
    if ((pulse_total - p0) !== 1 || o_edge_cnt !== 16'd4) begin
      errors++;
      $display("FAIL glitch_4: got pulses=%0d cnt=%0d expected 1 4", pulse_total - p0, o_edge_cnt);
    end
    checks++;
    if (o_period_cnt !== 32'd63) begin
      errors++; $display("FAIL glitch_4_period: got %0d expected 63", o_period_cnt);
    end
  endtask

  task automatic test_lost();
    int p0, v0;
    // 9 cycles have elapsed since the last pulse at this point.
    tick(90);
    checks++;
    if (o_signal_lost !== 1'b0) begin
      errors++; $display("FAIL lost_early: got %0b expected 0", o_signal_lost);
    end
    tick(1);
    checks++;
    if (o_signal_lost !== 1'b1) begin
      errors++; $display("FAIL lost_at_timeout: got %0b expected 1", o_signal_lost);
    end
    tick(20);
    checks++;
    if (o_signal_lost !== 1'b1 || o_period_cnt !== 32'd63) begin
      errors++;
      $display("FAIL lost_hold: got lost=%0b period=%0d expected 1 63", o_signal_lost, o_period_cnt);
    end
    p0 = pulse_total; v0 = valid_total;
    pulse_in(4, 10);
    checks++;
    if ((pulse_total - p0) !== 1 || (valid_total - v0) !== 0 || o_signal_lost !== 1'b0) begin
      errors++;
      $display("FAIL lost_recover: got pulses=%0d valids=%0d lost=%0b expected 1 0 0",
               pulse_total - p0, valid_total - v0, o_signal_lost);
    end
    checks++;
    if (o_period_cnt !== 32'd63 || o_edge_cnt !== 16'd5) begin
      errors++;
      $display("FAIL lost_recover_cnt: got period=%0d cnt=%0d expected 63 5", o_period_cnt, o_edge_cnt);
    end
  endtask

  task automatic test_wrap_disable();
    force dut.edge_cnt_r = 16'hFFF0;
    #1;
    release dut.edge_cnt_r;
    for (int i = 0; i < 15; i++) pulse_in(4, 4);
    checks++;
    if (o_edge_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload: got %0h expected ffff", o_edge_cnt);
    end
    pulse_in(4, 4);
    checks++;
    if (o_edge_cnt !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero: got %0h expected 0", o_edge_cnt);
    end
    tick(20);
    enable = 1'b0;
    tick(1);
    checks++;
    if ({o_edge_pulse, o_period_valid, o_period_cnt, o_edge_cnt, o_signal_lost} !== 51'd0) begin
      errors++;
      $display("FAIL disable_clear: got %0h expected 0",
               {o_edge_pulse, o_period_valid, o_period_cnt, o_edge_cnt, o_signal_lost});
    end
  endtask

  task automatic test_async_reset();
    int p0, v0;
    enable = 1'b1;
    tick(2);
    pulse_in(4, 10);
    pulse_in(4, 10);
    checks++;
    if (o_period_cnt !== 32'd14) begin
      errors++; $display("FAIL pre_reset_period: got %0d expected 14", o_period_cnt);
    end
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_edge_pulse, o_period_valid, o_period_cnt, o_edge_cnt, o_signal_lost} !== 51'd0) begin
      errors++;
      $display("FAIL async_reset: got %0h expected 0",
               {o_edge_pulse, o_period_valid, o_period_cnt, o_edge_cnt, o_signal_lost});
    end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    p0 = pulse_total;
    pulse_in(4, 10);
    checks++;
    if ((pulse_total - p0) !== 0) begin
      errors++; $display("FAIL post_reset_idle: got %0d expected 0", pulse_total - p0);
    end
    enable = 1'b1;
    tick(2);
    p0 = pulse_total; v0 = valid_total;
    pulse_in(4, 10);
    checks++;
    if ((pulse_total - p0) !== 1 || (valid_total - v0) !== 0 || o_edge_cnt !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_first: got pulses=%0d valids=%0d cnt=%0d expected 1 0 1",
               pulse_total - p0, valid_total - v0, o_edge_cnt);
    end
    pulse_in(4, 10);
    checks++;
    if ((valid_total - v0) !== 1 || o_period_cnt !== 32'd14) begin
      errors++;
      $display("FAIL post_reset_period: got valids=%0d period=%0d expected 1 14",
               valid_total - v0, o_period_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; sig = 1'b0;
    test_reset();
    test_first_edge();
    test_period();
    test_glitch();
    test_lost();
    test_wrap_disable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
